// File: rtl/uart_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : uart_rx                                                    |
// | Description : 16x-oversampling UART receiver with holding register,     |
// |               frame-error pulse and sticky overrun flag.                 |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module uart_rx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            rx,
    input  logic            rd_uart,
    output logic [DBIT-1:0] dout,
    output logic            rx_valid,
    output logic            rx_done_tick,
    output logic            frame_err,
    output logic            overrun
);

    localparam int              c_NW      = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam logic [c_NW-1:0] c_N_LAST  = c_NW'(DBIT - 1);
    localparam logic [3:0]      c_SB_LAST = 4'(SB_TICK - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t            r_state;
    logic [3:0]        r_s;
    logic [c_NW-1:0]   r_n;
    logic [DBIT-1:0]   r_b;
    logic              r_rx_meta;
    logic              r_rx_s;

    logic              w_stop_end;
    logic              w_frame_ok;

    // Final stop-bit sample; outputs are committed on this clock.
    assign w_stop_end = (r_state == ST_STOP) && s_tick && (r_s == c_SB_LAST);
    assign w_frame_ok = w_stop_end && r_rx_s;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_s          <= '0;
            r_n          <= '0;
            r_b          <= '0;
            dout         <= '0;
            rx_valid     <= 1'b0;
            rx_done_tick <= 1'b0;
            frame_err    <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            rx_done_tick <= w_frame_ok;
            frame_err    <= w_stop_end && !r_rx_s;

            case (r_state)
                ST_IDLE: begin
                    if (!r_rx_s) begin
                        r_state <= ST_START;
                        r_s     <= '0;
                    end
                end
                ST_START: begin
                    if (s_tick) begin
                        if (r_s == 4'd7) begin
                            // A high line at mid start bit is a glitch, not a frame.
                            if (!r_rx_s) begin
                                r_state <= ST_DATA;
                                r_s     <= '0;
                                r_n     <= '0;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            r_s <= r_s + 4'd1;
                        end
                    end
                end
                ST_DATA: begin
                    if (s_tick) begin
                        if (r_s == 4'd15) begin
                            r_s <= '0;
                            r_b <= {r_rx_s, r_b[DBIT-1:1]};
                            if (r_n == c_N_LAST) begin
                                r_state <= ST_STOP;
                            end else begin
                                r_n <= r_n + 1'b1;
                            end
                        end else begin
                            r_s <= r_s + 4'd1;
                        end
                    end
                end
                ST_STOP: begin
                    if (s_tick) begin
                        if (r_s == c_SB_LAST) begin
                            r_state <= ST_IDLE;
                            r_s     <= '0;
                        end else begin
                            r_s <= r_s + 4'd1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            // A simultaneous read consumes the old word, so the new one is not an overrun.
            if (w_frame_ok) begin
                dout     <= r_b;
                rx_valid <= 1'b1;
                if (rx_valid) begin
                    overrun <= !rd_uart;
                end
            end else if (rd_uart && rx_valid) begin
                rx_valid <= 1'b0;
                overrun  <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_uart_rx                                                 |
// | Description : Scoreboard testbench for uart_rx with randomized frames.   |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module tb_uart_rx;

    localparam int c_DBIT    = 8;
    localparam int c_SB_TICK = 16;

    logic              clk;
    logic              reset;
    logic              s_tick;
    logic              rx;
    logic              rd_uart;
    logic [c_DBIT-1:0] dout;
    logic              rx_valid;
    logic              rx_done_tick;
    logic              frame_err;
    logic              overrun;

    uart_rx #(.DBIT(c_DBIT), .SB_TICK(c_SB_TICK)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .s_tick       (s_tick),
        .rx           (rx),
        .rd_uart      (rd_uart),
        .dout         (dout),
        .rx_valid     (rx_valid),
        .rx_done_tick (rx_done_tick),
        .frame_err    (frame_err),
        .overrun      (overrun)
    );

    typedef struct {
        logic              is_err;
        logic [c_DBIT-1:0] data;
        logic              valid;
        logic              ovr;
    } exp_t;

    exp_t              sb[$];
    int                n_checks = 0;
    int                n_err    = 0;

    // Reference state of the receiver's visible holding register.
    logic [c_DBIT-1:0] m_dout  = '0;
    logic              m_valid = 1'b0;
    logic              m_ovr   = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset && (rx_done_tick || frame_err)) begin
            if (rx_done_tick && frame_err) check("both_pulses", 32'd1, 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_pulse", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("pulse_kind_err", {31'd0, frame_err}, {31'd0, e.is_err});
                check("pulse_dout", {24'd0, dout}, {24'd0, e.data});
                check("pulse_rx_valid", {31'd0, rx_valid}, {31'd0, e.valid});
                check("pulse_overrun", {31'd0, overrun}, {31'd0, e.ovr});
            end
        end
    end

    task automatic clk_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tick(input logic rd);
        s_tick  = 1'b1;
        rd_uart = rd;
        @(negedge clk);
        s_tick  = 1'b0;
        rd_uart = 1'b0;
        clk_n($urandom_range(2, 5));
    endtask

    task automatic idle_ticks(input int n);
        rx = 1'b1;
        repeat (n) tick(1'b0);
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_dout"}, {24'd0, dout}, {24'd0, m_dout});
        check({tag, "_rx_valid"}, {31'd0, rx_valid}, {31'd0, m_valid});
        check({tag, "_overrun"}, {31'd0, overrun}, {31'd0, m_ovr});
        check({tag, "_done"}, {31'd0, rx_done_tick}, 32'd0);
        check({tag, "_ferr"}, {31'd0, frame_err}, 32'd0);
    endtask

    task automatic do_read();
        rd_uart = 1'b1;
        @(negedge clk);
        rd_uart = 1'b0;
        if (m_valid) begin
            m_valid = 1'b0;
            m_ovr   = 1'b0;
        end
        check("read_rx_valid", {31'd0, rx_valid}, {31'd0, m_valid});
        check("read_overrun", {31'd0, overrun}, {31'd0, m_ovr});
    endtask

    // Drives one frame; bit time is 16 ticks, mid-start sample after 8 ticks.
    task automatic send_frame(input logic [c_DBIT-1:0] data, input logic stop_bit,
                              input logic rd_end, input int abort_bit);
        exp_t e;
        rx = 1'b0;
        clk_n(3);
        repeat (8) tick(1'b0);
        for (int i = 0; i < c_DBIT; i++) begin
            rx = data[i];
            if (i == abort_bit) begin
                repeat (5) tick(1'b0);
                reset = 1'b0;
                #1;
                m_dout  = '0;
                m_valid = 1'b0;
                m_ovr   = 1'b0;
                check_outputs("reset_mid");
                @(negedge clk);
                rx = 1'b1;
                @(negedge clk);
                reset = 1'b1;
                clk_n(3);
                idle_ticks(20);
                check_outputs("after_abort");
                return;
            end
            repeat (16) tick(1'b0);
        end
        rx = stop_bit;
        if (stop_bit) begin
            if (m_valid) m_ovr = !rd_end;
            m_valid = 1'b1;
            m_dout  = data;
            e.is_err = 1'b0;
        end else begin
            if (rd_end && m_valid) begin
                m_valid = 1'b0;
                m_ovr   = 1'b0;
            end
            e.is_err = 1'b1;
        end
        e.data  = m_dout;
        e.valid = m_valid;
        e.ovr   = m_ovr;
        sb.push_back(e);
        repeat (c_SB_TICK - 1) tick(1'b0);
        tick(rd_end);
        check("pulse_seen", sb.size(), 32'd0);
        sb.delete();
        idle_ticks(10);
    endtask

    task automatic send_glitch(input int low_ticks);
        rx = 1'b0;
        clk_n(3);
        repeat (low_ticks) tick(1'b0);
        idle_ticks(12);
        check_outputs("glitch");
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset   = 1'b0;
        s_tick  = 1'b0;
        rx      = 1'b1;
        rd_uart = 1'b0;
        clk_n(4);
        check_outputs("reset");
        reset = 1'b1;
        clk_n(3);
        idle_ticks(5);
        check_outputs("idle_ticks");

        send_frame(8'hA5, 1'b1, 1'b0, -1);
        do_read();

        send_glitch(4);
        send_frame(8'h3C, 1'b1, 1'b0, -1);

        send_frame(8'h55, 1'b0, 1'b0, -1);
        check_outputs("after_ferr");
        do_read();

        send_frame(8'h11, 1'b1, 1'b0, -1);
        send_frame(8'h22, 1'b1, 1'b0, -1);
        check_outputs("overrun");
        do_read();

        send_frame(8'h11, 1'b1, 1'b0, -1);
        send_frame(8'h7E, 1'b1, 1'b1, -1);
        check_outputs("coincident_read");
        do_read();

        send_frame(8'h9A, 1'b1, 1'b0, -1);
        send_frame(8'hF0, 1'b1, 1'b0, 4);
        send_frame(8'hC3, 1'b1, 1'b0, -1);
        do_read();

        for (int k = 0; k < 20; k++) begin
            if ($urandom_range(0, 4) == 0) send_glitch($urandom_range(1, 7));
            send_frame(8'($urandom), ($urandom_range(0, 9) != 0),
                       ($urandom_range(0, 3) == 0), -1);
            if ($urandom_range(0, 1) == 1) do_read();
        end
        check_outputs("final");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
